// File: rtl/sdram_pkg.sv
// Shared SDRAM types and widths used by the command-port scheduler and the controller.
package sdram_pkg;

  localparam int unsigned SDRAM_AW = 24;
  localparam int unsigned SDRAM_DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACK
  } sched_state_t;

endpackage

// File: rtl/sdram_sched_rr_pick.sv
// Round-robin pick: first set request at or above ptr_i, wrapping back to RT.
module rr_pick #(
  parameter int N  = 4,
  parameter int RT = 1,
  parameter int IW = $clog2(N + 1)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Lowest pending non-RT index is the wrap fallback; lowest at/above ptr_i overrides it.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i >= RT && req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (i >= RT && i >= int'(ptr_i) && req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/sdram_sched.sv
// Shares the SDRAM command port: fixed priority for the real-time class, round-robin
// with starvation override for the rest; the granted command is latched before issue.
module sdram_sched
  import sdram_pkg::*;
#(
  parameter int N      = 4,
  parameter int RT     = 1,
  parameter int STARVE = 8,
  parameter int AW     = int'(SDRAM_AW),
  parameter int DW     = int'(SDRAM_DW)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    we,
  input  logic [N*AW-1:0] addr,
  input  logic [N*DW-1:0] data,
  output logic [N-1:0]    rdy,
  output logic [N-1:0]    sel,
  output logic            if_req,
  output logic            if_we,
  output logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_data,
  input  logic            if_rdy,
  output logic            busy
);

  localparam int IW = $clog2(N + 1);

  sched_state_t  state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [7:0]    starve_q, starve_d;

  logic          rr_valid;
  logic [IW-1:0] rr_idx;
  logic          rt_valid;
  logic [IW-1:0] rt_idx;
  logic          nrt_pend;
  logic          win_nrt;
  logic [IW-1:0] g_c;

  rr_pick #(.N(N), .RT(RT), .IW(IW)) u_rr_pick (
    .req_i  (req),
    .ptr_i  (rr_q),
    .valid_o(rr_valid),
    .idx_o  (rr_idx)
  );

  // Winner: starvation override, else lowest real-time index, else round-robin.
  always_comb begin
    rt_valid = 1'b0;
    rt_idx   = '0;
    nrt_pend = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i < RT && req[i]) begin
        rt_valid = 1'b1;
        rt_idx   = IW'(i);
      end
      if (i >= RT && req[i]) nrt_pend = 1'b1;
    end
    win_nrt = ((starve_q >= 8'(STARVE)) && rr_valid) || !rt_valid;
    g_c     = win_nrt ? rr_idx : rt_idx;
  end

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    we_d     = we_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rr_d     = rr_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ISSUE;
          g_d     = g_c;
          for (int i = 0; i < N; i++) begin
            if (g_c == IW'(i)) begin
              we_d   = we[i];
              addr_d = addr[i*AW +: AW];
              data_d = data[i*DW +: DW];
            end
          end
          if (win_nrt) begin
            starve_d = '0;
            rr_d     = (int'(g_c) == N - 1) ? IW'(RT) : g_c + IW'(1);
          end else if (nrt_pend) begin
            if (starve_q != 8'hFF) starve_d = starve_q + 8'd1;
          end else begin
            starve_d = '0;
          end
        end else begin
          starve_d = '0;
        end
      end
      ISSUE:   if (if_rdy) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      g_q      <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rr_q     <= IW'(RT);
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rr_q     <= rr_d;
      starve_q <= starve_d;
    end
  end

  // Outputs decode only from state and latched registers.
  always_comb begin
    sel = '0;
    rdy = '0;
    for (int i = 0; i < N; i++) begin
      if (g_q == IW'(i)) begin
        sel[i] = (state_q != IDLE);
        rdy[i] = (state_q == ACK);
      end
    end
    if_req  = (state_q == ISSUE);
    if_we   = we_q;
    if_addr = addr_q;
    if_data = data_q;
    busy    = (state_q != IDLE);
  end

endmodule

// File: tb/tb_sdram_sched.sv
// Self-checking bench for sdram_sched: directed scenarios plus a randomized run
// against a transaction-level arbitration model.
module tb_sdram_sched;

  localparam int N      = 4;
  localparam int RT     = 1;
  localparam int STARVE = 2;
  localparam int AW     = 24;
  localparam int DW     = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0]    rdy;
  logic [N-1:0]    sel;
  logic            if_req;
  logic            if_we;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_data;
  logic            if_rdy = 1'b0;
  logic            busy;

  int tests = 0;
  int fails = 0;

  // Transaction-level model state
  int            m_phase;
  int            m_g;
  int            m_rr;
  int            m_starve;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  always #5 clk = ~clk;

  sdram_sched #(.N(N), .RT(RT), .STARVE(STARVE), .AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .data   (data),
    .rdy    (rdy),
    .sel    (sel),
    .if_req (if_req),
    .if_we  (if_we),
    .if_addr(if_addr),
    .if_data(if_data),
    .if_rdy (if_rdy),
    .busy   (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    req    = '0;
    if_rdy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic int onehot_idx(logic [N-1:0] v);
    int r = -1;
    for (int j = 0; j < N; j++) if (v[j]) r = j;
    return r;
  endfunction

  // Spec-level winner: override, then lowest RT index, then round-robin scan.
  function automatic int model_pick(logic [N-1:0] r);
    int rrw = -1;
    int j;
    for (int k = 0; k < N - RT; k++) begin
      j = RT + ((m_rr - RT + k) % (N - RT));
      if (rrw < 0 && r[j]) rrw = j;
    end
    if (m_starve >= STARVE && rrw >= 0) return rrw;
    for (int i = 0; i < RT; i++) if (r[i]) return i;
    return rrw;
  endfunction

  task automatic test_reset();
    we   = '1;
    addr = {$urandom, $urandom, $urandom};
    do_reset();
    tests++; if (sel !== '0)     begin fails++; $display("FAIL reset_sel got %b exp 0", sel); end
    tests++; if (rdy !== '0)     begin fails++; $display("FAIL reset_rdy got %b exp 0", rdy); end
    tests++; if (if_req !== 1'b0) begin fails++; $display("FAIL reset_if_req got %b exp 0", if_req); end
    tests++; if (if_we !== 1'b0) begin fails++; $display("FAIL reset_if_we got %b exp 0", if_we); end
    tests++; if (if_addr !== '0) begin fails++; $display("FAIL reset_if_addr got %h exp 0", if_addr); end
    tests++; if (if_data !== '0) begin fails++; $display("FAIL reset_if_data got %h exp 0", if_data); end
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    we = '0;
  endtask

  task automatic test_single();
    req = 4'b0100;
    we  = 4'b0100;
    addr[2*AW +: AW] = 24'hF00010;
    data[2*DW +: DW] = 16'h1234;
    if_rdy = 1'b0;
    @(negedge clk);
    tests++; if (if_req !== 1'b1) begin fails++; $display("FAIL single_if_req got %b exp 1", if_req); end
    tests++; if (if_we !== 1'b1) begin fails++; $display("FAIL single_if_we got %b exp 1", if_we); end
    tests++; if (if_addr !== 24'hF00010) begin fails++; $display("FAIL single_if_addr got %h exp f00010", if_addr); end
    tests++; if (if_data !== 16'h1234) begin fails++; $display("FAIL single_if_data got %h exp 1234", if_data); end
    tests++; if (sel !== 4'b0100) begin fails++; $display("FAIL single_sel got %b exp 0100", sel); end
    @(negedge clk);
    tests++; if (rdy !== '0 || if_req !== 1'b1) begin fails++; $display("FAIL single_wait rdy %b if_req %b exp 0000 1", rdy, if_req); end
    @(negedge clk);
    if_rdy = 1'b1;
    @(negedge clk);
    if_rdy = 1'b0;
    tests++; if (rdy !== 4'b0100) begin fails++; $display("FAIL single_rdy got %b exp 0100", rdy); end
    tests++; if (if_req !== 1'b0) begin fails++; $display("FAIL single_ack_if_req got %b exp 0", if_req); end
    req = '0;
    we  = '0;
    @(negedge clk);
    tests++; if (rdy !== '0 || busy !== 1'b0) begin fails++; $display("FAIL single_after rdy %b busy %b exp 0000 0", rdy, busy); end
  endtask

  task automatic grant_order(input logic [N-1:0] pattern, input string name, input int e0,
                             input int e1, input int e2, input int e3, input int e4, input int e5);
    int got[$];
    int exp_q[6];
    exp_q = '{e0, e1, e2, e3, e4, e5};
    do_reset();
    req    = pattern;
    if_rdy = 1'b1;
    for (int c = 0; c < 60 && got.size() < 6; c++) begin
      @(negedge clk);
      if (rdy !== '0) got.push_back(onehot_idx(rdy));
    end
    req    = '0;
    if_rdy = 1'b0;
    @(negedge clk);
    tests++;
    if (got.size() != 6) begin
      fails++; $display("FAIL %s_count got %0d grants exp 6", name, got.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        tests++;
        if (got[k] != exp_q[k]) begin fails++; $display("FAIL %s_grant%0d got %0d exp %0d", name, k, got[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_round_robin();
    grant_order(4'b1110, "rr", 1, 2, 3, 1, 2, 3);
  endtask

  task automatic test_priority_starve();
    grant_order(4'b0101, "prio", 0, 0, 2, 0, 0, 2);
  endtask

  task automatic test_change_issue();
    req = 4'b1000;
    we  = 4'b0000;
    addr[3*AW +: AW] = 24'h123456;
    data[3*DW +: DW] = 16'hBEEF;
    if_rdy = 1'b0;
    @(negedge clk);
    addr[3*AW +: AW] = 24'hABCDEF;
    data[3*DW +: DW] = 16'h0000;
    req = '0;
    tests++; if (sel !== 4'b1000) begin fails++; $display("FAIL chg_sel got %b exp 1000", sel); end
    @(negedge clk);
    tests++; if (if_addr !== 24'h123456) begin fails++; $display("FAIL chg_if_addr got %h exp 123456", if_addr); end
    tests++; if (if_data !== 16'hBEEF) begin fails++; $display("FAIL chg_if_data got %h exp beef", if_data); end
    tests++; if (if_req !== 1'b1) begin fails++; $display("FAIL chg_if_req got %b exp 1", if_req); end
    if_rdy = 1'b1;
    @(negedge clk);
    if_rdy = 1'b0;
    tests++; if (rdy !== 4'b1000) begin fails++; $display("FAIL chg_rdy got %b exp 1000", rdy); end
    @(negedge clk);
    tests++; if (rdy !== '0 || busy !== 1'b0) begin fails++; $display("FAIL chg_after rdy %b busy %b exp 0000 0", rdy, busy); end
  endtask

  task automatic test_reset_in_issue();
    req    = 4'b0010;
    if_rdy = 1'b0;
    @(negedge clk);
    tests++; if (if_req !== 1'b1) begin fails++; $display("FAIL rsti_pre if_req got %b exp 1", if_req); end
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    reset = 1'b0;
    tests++; if (if_req !== 1'b0) begin fails++; $display("FAIL rsti_if_req got %b exp 0", if_req); end
    tests++; if (sel !== '0) begin fails++; $display("FAIL rsti_sel got %b exp 0", sel); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rsti_busy got %b exp 0", busy); end
    tests++; if (rdy !== '0) begin fails++; $display("FAIL rsti_rdy got %b exp 0", rdy); end
    req    = 4'b1110;
    if_rdy = 1'b1;
    @(negedge clk);
    tests++; if (sel !== 4'b0010) begin fails++; $display("FAIL rsti_rrptr sel got %b exp 0010", sel); end
    @(negedge clk);
    tests++; if (rdy !== 4'b0010) begin fails++; $display("FAIL rsti_retry_rdy got %b exp 0010", rdy); end
    req    = '0;
    if_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle();
    int bad = 0;
    req = '0;
    for (int c = 0; c < 100; c++) begin
      if_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      tests++;
      if (if_req !== 1'b0 || rdy !== '0 || busy !== 1'b0) begin
        fails++;
        if (bad < 5) $display("FAIL idle cyc %0d if_req %b rdy %b busy %b exp 0 0000 0", c, if_req, rdy, busy);
        bad++;
      end
    end
    if_rdy = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] e_sel;
    logic [N-1:0] e_rdy;
    logic         nrt_pend;
    int           w;
    int           bad = 0;
    do_reset();
    m_phase = 0; m_g = 0; m_rr = RT; m_starve = 0;
    m_we = 1'b0; m_addr = '0; m_data = '0;
    for (int c = 0; c < 600; c++) begin
      e_sel = (m_phase != 0) ? N'(1) << m_g : '0;
      e_rdy = (m_phase == 2) ? N'(1) << m_g : '0;
      tests++;
      if (sel !== e_sel || rdy !== e_rdy || if_req !== (m_phase == 1) || busy !== (m_phase != 0)) begin
        fails++;
        if (bad < 5) $display("FAIL rand_ctrl cyc %0d sel %b rdy %b if_req %b busy %b exp %b %b %b %b",
                              c, sel, rdy, if_req, busy, e_sel, e_rdy, m_phase == 1, m_phase != 0);
        bad++;
      end
      if (m_phase == 1) begin
        tests++;
        if (if_we !== m_we || if_addr !== m_addr || if_data !== m_data) begin
          fails++;
          if (bad < 5) $display("FAIL rand_cmd cyc %0d we %b addr %h data %h exp %b %h %h",
                                c, if_we, if_addr, if_data, m_we, m_addr, m_data);
          bad++;
        end
      end
      // Requesters hold req until acknowledged, then may re-request immediately.
      for (int i = 0; i < N; i++) begin
        if (!req[i] || e_rdy[i]) req[i] = ($urandom_range(0, 2) == 0);
        we[i] = 1'($urandom_range(0, 1));
        addr[i*AW +: AW] = AW'($urandom);
        data[i*DW +: DW] = DW'($urandom);
      end
      if_rdy = 1'($urandom_range(0, 1));
      nrt_pend = 1'b0;
      for (int i = RT; i < N; i++) if (req[i]) nrt_pend = 1'b1;
      case (m_phase)
        0: begin
          if (req != '0) begin
            w = model_pick(req);
            m_g = w; m_we = we[w]; m_addr = addr[w*AW +: AW]; m_data = data[w*DW +: DW];
            if (w >= RT) begin
              m_starve = 0;
              m_rr = (w == N - 1) ? RT : w + 1;
            end else if (nrt_pend) begin
              m_starve = (m_starve < 255) ? m_starve + 1 : 255;
            end else begin
              m_starve = 0;
            end
            m_phase = 1;
          end else begin
            m_starve = 0;
          end
        end
        1: if (if_rdy) m_phase = 2;
        default: m_phase = 0;
      endcase
      @(negedge clk);
    end
    req    = '0;
    if_rdy = 1'b1;
    repeat (4) @(negedge clk);
    if_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority_starve();
    test_change_issue();
    test_reset_in_issue();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
